// File: rtl/datapath_mc.sv
// Multicycle register-file datapath: IDLE -> RDA -> RDB -> EXEC -> WB.
// Optional macro DATAPATH_MC_STATUS_EXT_EN enables the N and V status flags;
// without it only Z is produced and status[2:1] read as zero.
module datapath_mc #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 5,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ext_load,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    ra,
  input  logic [RW-1:0]    rb,
  input  logic [1:0]       alu_op,
  input  logic [1:0]       shift,
  input  logic             use_imm,
  input  logic             zero_a,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] datapath_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] datapath_out,
  output logic [2:0]       status
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_RDB  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  logic [2:0]       r_state;
  logic             r_ext;
  logic [RW-1:0]    r_rd;
  logic [RW-1:0]    r_ra;
  logic [RW-1:0]    r_rb;
  logic [1:0]       r_op;
  logic [1:0]       r_shift;
  logic             r_use_imm;
  logic             r_zero_a;
  logic [IMM_W-1:0] r_imm;
  logic [WIDTH-1:0] r_din;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_status;

  logic [WIDTH-1:0] w_aop;
  logic [WIDTH-1:0] w_bsh;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH-1:0] w_res;
  logic [2:0]       w_status;
`ifdef DATAPATH_MC_STATUS_EXT_EN
  logic             w_v;
`endif

  // Sequencer and command latch; start is only honoured in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ext     <= 1'b0;
      r_rd      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_op      <= '0;
      r_shift   <= '0;
      r_use_imm <= 1'b0;
      r_zero_a  <= 1'b0;
      r_imm     <= '0;
      r_din     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ext     <= ext_load;
            r_rd      <= rd;
            r_ra      <= ra;
            r_rb      <= rb;
            r_op      <= alu_op;
            r_shift   <= shift;
            r_use_imm <= use_imm;
            r_zero_a  <= zero_a;
            r_imm     <= imm;
            r_din     <= datapath_in;
            r_state   <= ext_load ? S_WB : S_RDA;
          end
        end
        S_RDA:   r_state <= S_RDB;
        S_RDB:   r_state <= S_EXEC;
        S_EXEC:  r_state <= S_WB;
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand registers A/B, result C and flags, each loaded only in its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
    end else begin
      if (r_state == S_RDA) r_a <= r_regs[r_ra];
      if (r_state == S_RDB) r_b <= r_regs[r_rb];
      if (r_state == S_EXEC) begin
        r_c      <= w_res;
        r_status <= w_status;
      end
    end
  end

  // Register file: single write port in WB, reads are combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (r_state == S_WB) begin
      r_regs[r_rd] <= r_ext ? r_din : r_c;
    end
  end

  // Operand selection, B pre-shift, ALU and flag generation.
  always_comb begin
    w_aop = r_zero_a ? '0 : r_a;
    case (r_shift)
      2'b01:   w_bsh = {r_b[WIDTH-2:0], 1'b0};
      2'b10:   w_bsh = {1'b0, r_b[WIDTH-1:1]};
      2'b11:   w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_bsh = r_b;
    endcase
    w_bop = r_use_imm ? {{(WIDTH-IMM_W){1'b0}}, r_imm} : w_bsh;
    case (r_op)
      2'b00:   w_res = w_aop + w_bop;
      2'b01:   w_res = w_aop - w_bop;
      2'b10:   w_res = w_aop & w_bop;
      default: w_res = ~w_bop;
    endcase
`ifdef DATAPATH_MC_STATUS_EXT_EN
    case (r_op)
      2'b00:   w_v = (w_aop[WIDTH-1] == w_bop[WIDTH-1]) && (w_res[WIDTH-1] != w_aop[WIDTH-1]);
      2'b01:   w_v = (w_aop[WIDTH-1] != w_bop[WIDTH-1]) && (w_res[WIDTH-1] != w_aop[WIDTH-1]);
      default: w_v = 1'b0;
    endcase
    w_status = {w_v, w_res[WIDTH-1], (w_res == '0)};
`else
    w_status = {2'b00, (w_res == '0)};
`endif
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_WB);
  assign datapath_out = r_c;
  assign status       = r_status;

endmodule

// File: tb/tb_datapath_mc.sv
module tb_datapath_mc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ext_load;
  logic [2:0]  rd, ra, rb;
  logic [1:0]  alu_op, shift;
  logic        use_imm, zero_a;
  logic [4:0]  imm;
  logic [15:0] datapath_in;
  logic        busy, done;
  logic [15:0] datapath_out;
  logic [2:0]  status;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] out;
    logic [2:0]  st;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mregs [8];
  logic [15:0] mc;
  logic [2:0]  mst;

  datapath_mc #(.WIDTH(16), .NREGS(8), .IMM_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ext_load(ext_load),
    .rd(rd), .ra(ra), .rb(rb), .alu_op(alu_op), .shift(shift),
    .use_imm(use_imm), .zero_a(zero_a), .imm(imm), .datapath_in(datapath_in),
    .busy(busy), .done(done), .datapath_out(datapath_out), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one operation; updates the model state.
  function automatic exp_t model(input logic ext, input logic [2:0] d, a, b,
                                 input logic [1:0] op, sh, input logic ui, za,
                                 input logic [4:0] im, input logic [15:0] din);
    exp_t e;
    logic [15:0] av, bs, bv, r;
    logic v;
    if (ext) begin
      mregs[d] = din;
      e.lat = 1;
    end else begin
      av = za ? 16'h0 : mregs[a];
      bs = mregs[b];
      case (sh)
        2'b01: bs = bs << 1;
        2'b10: bs = bs >> 1;
        2'b11: bs = {bs[15], bs[15:1]};
        default: ;
      endcase
      bv = ui ? {11'b0, im} : bs;
      v = 1'b0;
      case (op)
        2'b00: begin r = av + bv; v = (av[15] == bv[15]) && (r[15] != av[15]); end
        2'b01: begin r = av - bv; v = (av[15] != bv[15]) && (r[15] != av[15]); end
        2'b10: r = av & bv;
        default: r = ~bv;
      endcase
      mc = r;
`ifdef DATAPATH_MC_STATUS_EXT_EN
      mst = {v, r[15], (r == 16'h0)};
`else
      mst = {2'b00, (r == 16'h0)};
`endif
      mregs[d] = r;
      e.lat = 4;
    end
    e.out = mc;
    e.st  = mst;
    return e;
  endfunction

  task automatic drive(input logic ext, input logic [2:0] d, a, b,
                       input logic [1:0] op, sh, input logic ui, za,
                       input logic [4:0] im, input logic [15:0] din);
    ext_load = ext; rd = d; ra = a; rb = b; alu_op = op; shift = sh;
    use_imm = ui; zero_a = za; imm = im; datapath_in = din;
  endtask

  // Issues one operation from IDLE and checks it when done appears.
  task automatic issue(input string nm, input logic ext, input logic [2:0] d, a, b,
                       input logic [1:0] op, sh, input logic ui, za,
                       input logic [4:0] im, input logic [15:0] din);
    exp_t e;
    int n = 0;
    int guard = 0;
    while (busy && guard < 20) begin @(negedge clk); guard++; end
    drive(ext, d, a, b, op, sh, ui, za, im, din);
    start = 1'b1;
    q.push_back(model(ext, d, a, b, op, sh, ui, za, im, din));
    do begin
      @(posedge clk); n++;
      @(negedge clk); start = 1'b0;
    end while (!done && n < 20);
    e = q.pop_front();
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s timeout: done never rose within %0d cycles", nm, n);
    end else begin
      checks++;
      if (n !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, n, e.lat); end
      checks++;
      if (datapath_out !== e.out) begin errors++; $display("FAIL %s out: got %h want %h", nm, datapath_out, e.out); end
      checks++;
      if (status !== e.st) begin errors++; $display("FAIL %s status: got %b want %b", nm, status, e.st); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s pulse: done=%b busy=%b want 0 0", nm, done, busy);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mc = 16'h0;
    mst = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || datapath_out !== 16'h0 || status !== 3'b000) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b out=%h st=%b want 0 0 0000 000",
                         busy, done, datapath_out, status);
    end
    rst_n = 1'b1;
    // first start on the first edge with reset released
    issue("rst_first", 1'b1, 3'd7, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h00AA);
    issue("rst_r0", 1'b0, 3'd6, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  task automatic test_ext_add();
    issue("ext_r1", 1'b1, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0005);
    issue("add_r1r1", 1'b0, 3'd2, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  task automatic test_overflow();
    issue("ext_7fff", 1'b1, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h7FFF);
    issue("ext_0001", 1'b1, 3'd2, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0001);
    issue("add_ovf", 1'b0, 3'd3, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  task automatic test_sub_imm();
    issue("sub_zero", 1'b0, 3'd3, 3'd1, 3'd1, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
    issue("imm31", 1'b0, 3'd4, 3'd1, 3'd2, 2'b00, 2'b00, 1'b1, 1'b1, 5'd31, 16'h0);
    issue("sub_neg", 1'b0, 3'd5, 3'd2, 3'd1, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  task automatic test_shift_logic();
    issue("ext_8002", 1'b1, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h8002);
    issue("asr", 1'b0, 3'd2, 3'd0, 3'd1, 2'b00, 2'b11, 1'b0, 1'b1, 5'd0, 16'h0);
    issue("lsr", 1'b0, 3'd3, 3'd0, 3'd1, 2'b00, 2'b10, 1'b0, 1'b1, 5'd0, 16'h0);
    issue("lsl", 1'b0, 3'd4, 3'd0, 3'd1, 2'b00, 2'b01, 1'b0, 1'b1, 5'd0, 16'h0);
    issue("and", 1'b0, 3'd5, 3'd1, 3'd2, 2'b10, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
    issue("notb", 1'b0, 3'd6, 3'd0, 3'd3, 2'b11, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
    // ext_load leaves C and status as they were
    issue("ext_keep", 1'b1, 3'd7, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h1357);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    issue("b2b_seed", 1'b1, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0001);
    drive(1'b0, 3'd1, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      e = model(1'b0, 3'd1, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
      e.lat = (k == 0) ? 4 : 5;
      q.push_back(e);
    end
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); n++;
        @(negedge clk);
      end while (!done && n < 20);
      if (k == 2) start = 1'b0;
      e = q.pop_front();
      checks++;
      if (!done || n !== e.lat) begin
        errors++; $display("FAIL b2b_gap%0d: got %0d cycles done=%b want %0d", k, n, done, e.lat);
      end
      checks++;
      if (datapath_out !== e.out) begin
        errors++; $display("FAIL b2b_out%0d: got %h want %h", k, datapath_out, e.out);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_extra: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_exec();
    issue("rx_seed", 1'b1, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0003);
    drive(1'b0, 3'd4, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
    start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rx_inflight: busy=%b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || datapath_out !== 16'h0 || status !== 3'b000) begin
      errors++; $display("FAIL rx_async: busy=%b done=%b out=%h st=%b want 0 0 0000 000",
                         busy, done, datapath_out, status);
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    issue("rx_first", 1'b1, 3'd7, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h1234);
    issue("rx_rd", 1'b0, 3'd0, 3'd4, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
    issue("rx_ra", 1'b0, 3'd2, 3'd1, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_ext_add();
    test_overflow();
    test_sub_imm();
    test_shift_logic();
    test_back_to_back();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width (min 8).
REQ-002 SHALL have parameter NREGS, default 8, register count (power of 2, min 2); RW = clog2(NREGS).
REQ-003 SHALL have parameter IMM_W, default 5, immediate width (< WIDTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request a new operation.
REQ-007 SHALL have port ext_load  input  1  operation writes datapath_in to rd (no ALU).
REQ-008 SHALL have port rd, ra, rb  input  RW each  destination, A-source and B-source register indices.
REQ-009 SHALL have port alu_op  input  2  00 add, 01 sub (A-B), 10 and, 11 not B.
REQ-010 SHALL have port shift  input  2  B pre-shift: 00 none, 01 lsl 1, 10 lsr 1, 11 asr 1.
REQ-011 SHALL have port use_imm  input  1  B operand = zero-extended imm instead of shifted rb.
REQ-012 SHALL have port zero_a  input  1  A operand forced to 0.
REQ-013 SHALL have port imm  input  IMM_W  immediate.
REQ-014 SHALL have port datapath_in  input  WIDTH  external load data.
REQ-015 SHALL have port busy  output  1  high whenever FSM not in IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse in WB state.
REQ-017 SHALL have port datapath_out  output  WIDTH  result register C.
REQ-018 SHALL have port status  output  3  {V,N,Z} flag register.

Function
REQ-019 SHALL implement FSM states IDLE, RDA, RDB, EXEC, WB.
REQ-020 SHALL, in IDLE with start=1, latch all command inputs and go to WB if ext_load=1, else RDA; start SHALL be ignored when not IDLE.
REQ-021 SHALL sequence RDA->RDB->EXEC->WB->IDLE, one cycle each; RDA loads A=reg[ra], RDB loads B=reg[rb], EXEC loads C and status, WB writes reg[rd].
REQ-022 SHALL give latency: start sampled at edge 0 -> done high in cycle 4 (ALU op) or cycle 1 (ext_load).
REQ-023 SHALL, in WB, write C to reg[rd] for ALU ops and latched datapath_in for ext_load; C and status unchanged by ext_load.
REQ-024 SHALL compute modulo 2^WIDTH; operands after zero_a/use_imm/shift selection; shift applied only to register B.
REQ-025 SHALL set Z=(result==0), N=result[WIDTH-1], V=signed overflow for add/sub, V=0 for and/not.
REQ-026 SHALL allow start in the IDLE cycle directly after WB; the new op reads the value just written.
REQ-027 SHALL read register file combinationally; only write port is WB.
REQ-028 SHALL keep C, status, registers stable outside their load states.

Reset
REQ-029 SHALL, on rst_n=0, immediately clear all registers, A, B, C, status, busy, done and force IDLE.
REQ-030 SHALL abort any in-flight operation on reset with no register write; first start accepted on first edge with rst_n=1.

Configuration
REQ-031 SHALL support macro DATAPATH_MC_STATUS_EXT_EN: defined -> N and V flags as specified; undefined -> status[2:1] tied 0, only Z implemented, port width unchanged.

Verification
REQ-032 SHALL cover ext_load 16'h0005 to r1, then add r2=r1+r1 -> done at cycle 4, datapath_out=16'h000A, status=000.
REQ-033 SHALL cover r1=16'h7FFF, r2=16'h0001, add -> 16'h8000, status {V,N,Z}=110 (with _EN), 000 without.
REQ-034 SHALL cover sub r3=r1-r1 -> 0, Z=1; zero_a with use_imm imm=5'd31 add -> 16'h001F.
REQ-035 SHALL cover r1=16'h8002, shift=11, zero_a, add -> 16'hC001; shift=10 -> 16'h4001.
REQ-036 SHALL cover start held high during busy -> exactly one op per IDLE entry, back-to-back ops read prior result.
REQ-037 SHALL cover rst_n low in EXEC -> busy=0, done=0, rd unchanged (0), outputs 0 immediately.
